// File: rtl/fw_unit_if.sv
// fw_unit_if: tile stream bundle for the Floyd-Warshall tile engine.
// master = upstream/downstream side, slave = fw_unit.
interface fw_unit_if;
   logic [1:0]  phase;
   logic [63:0] inD;
   logic        in_valid;
   logic        inhibit;
   logic [63:0] outD;
   logic        out_valid;

   modport master (output phase, inD, in_valid, input inhibit, outD, out_valid);
   modport slave  (input phase, inD, in_valid, output inhibit, outD, out_valid);
endinterface

// File: rtl/fw_unit.sv
// fw_unit: 8x8 Floyd-Warshall tile engine (16-bit unsigned distances).
// LOAD collects 16/32/48 words depending on phase, COMP relaxes all 64
// entries per k for k=0..7, DRAIN streams the target tile back out.
// Optional build macro FW_DIAG_CLR_EN: in phase 00 the target diagonal is
// forced to zero while loading.
module fw_unit (
   input logic      clk,
   input logic      reset,
   fw_unit_if.slave bus
);
   typedef enum logic [1:0] {LOAD, COMP, DRAIN} state_t;
   typedef logic [7:0][7:0][15:0] tile_t;

   state_t          state_q, state_d;
   logic [5:0]      cnt_q, last_idx;
   logic [1:0]      ph_q, ph_eff;
   tile_t           t_q, a_q, b_q, t_nx;
   logic            acc, load_t, load_a, load_b;
   logic [2:0]      row, k;
   logic [3:0][15:0] wdat;
   logic [127:0]    drow;

   // Phase of the current word: live on the first word, latched afterwards.
   assign acc      = bus.in_valid && !bus.inhibit && (state_q == LOAD);
   assign ph_eff   = (cnt_q == 6'd0) ? bus.phase : ph_q;
   assign last_idx = (ph_eff == 2'b00) ? 6'd15 : (ph_eff == 2'b11) ? 6'd47 : 6'd31;
   // Target tile is always the final 16 words; A = P or C, B = R.
   assign load_t   = (cnt_q[5:4] == last_idx[5:4]);
   assign load_a   = !load_t && (cnt_q[5:4] == 2'd0);
   assign load_b   = !load_t && (cnt_q[5:4] == 2'd1);
   assign row      = cnt_q[3:1];
   assign k        = cnt_q[2:0];
   assign drow     = t_q[row];

   // Unpack the incoming word into its four column elements.
   always_comb begin
      for (int q = 0; q < 4; q++) begin
         wdat[q] = bus.inD[16*q +: 16];
`ifdef FW_DIAG_CLR_EN
         if (ph_eff == 2'b00 && load_t && {cnt_q[0], 2'(q)} == row) wdat[q] = 16'h0;
`endif
      end
   end

   // Relaxation array: one candidate path per entry, 17-bit sum so no wrap.
   for (genvar i = 0; i < 8; i++) begin : g_row
      for (genvar j = 0; j < 8; j++) begin : g_col
         logic [15:0] x, y;
         logic [16:0] sum;
         assign x   = ph_q[0] ? a_q[i][k] : t_q[i][k];
         assign y   = !ph_q[1] ? t_q[k][j] : (ph_q[0] ? b_q[k][j] : a_q[k][j]);
         assign sum = {1'b0, x} + {1'b0, y};
         assign t_nx[i][j] = (sum < {1'b0, t_q[i][j]}) ? sum[15:0] : t_q[i][j];
      end
   end

   // State register; inhibit registered off the next state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= LOAD;
         bus.inhibit <= 1'b0;
      end else begin
         state_q     <= state_d;
         bus.inhibit <= (state_d != LOAD);
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         LOAD:    if (acc && cnt_q == last_idx) state_d = COMP;
         COMP:    if (k == 3'd7) state_d = DRAIN;
         DRAIN:   if (cnt_q[3:0] == 4'd15) state_d = LOAD;
         default: state_d = LOAD;
      endcase
   end

   // Datapath: tile buffers, word/k/output counter and output register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q         <= '0;
         ph_q          <= '0;
         t_q           <= '0;
         a_q           <= '0;
         b_q           <= '0;
         bus.outD      <= '0;
         bus.out_valid <= 1'b0;
      end else begin
         unique case (state_q)
            LOAD: begin
               bus.out_valid <= 1'b0;
               if (acc) begin
                  if (cnt_q == 6'd0) ph_q <= bus.phase;
                  for (int q = 0; q < 4; q++) begin
                     if (load_t) t_q[row][{cnt_q[0], 2'(q)}] <= wdat[q];
                     if (load_a) a_q[row][{cnt_q[0], 2'(q)}] <= wdat[q];
                     if (load_b) b_q[row][{cnt_q[0], 2'(q)}] <= wdat[q];
                  end
                  cnt_q <= (cnt_q == last_idx) ? 6'd0 : cnt_q + 6'd1;
               end
            end
            COMP: begin
               t_q   <= t_nx;
               cnt_q <= (k == 3'd7) ? 6'd0 : cnt_q + 6'd1;
            end
            DRAIN: begin
               bus.outD      <= cnt_q[0] ? drow[127:64] : drow[63:0];
               bus.out_valid <= 1'b1;
               cnt_q         <= (cnt_q[3:0] == 4'd15) ? 6'd0 : cnt_q + 6'd1;
            end
            default: cnt_q <= '0;
         endcase
      end
   end
endmodule

// File: tb/tb_fw_unit.sv
// tb_fw_unit: table-driven jobs with a scoreboard of expected output words,
// plus hand sequences for bubbles, inhibit/back-to-back and reset abort.
module tb_fw_unit;
   typedef logic [7:0][7:0][15:0] tile_t;
   typedef struct {
      string       name;
      logic [1:0]  ph;
      tile_t       a, b, t;
      int          ci, cj;
      logic [15:0] cval;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fw_unit_if bus ();
   fw_unit dut (.clk(clk), .reset(rst_n), .bus(bus));

   int total = 0, bad = 0, cyc = 0, done_cnt = 0;
   logic [63:0] exp_q[$];
   int          acc_q[$];
   tile_t       cap;
   int          run_len = 0, ow = 0, ta;
   logic [63:0] ew;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, req);
      end
   endtask

   task automatic fail(input string nm);
      total++;
      bad++;
      $display("FAIL %s", nm);
   endtask

   function automatic logic [63:0] word_of(input tile_t x, input int wi);
      logic [63:0] w;
      for (int q = 0; q < 4; q++) w[16*q +: 16] = x[wi/2][4*(wi%2)+q];
      return w;
   endfunction

   // Reference: parallel relaxation per k using the previous-k tile.
   function automatic tile_t fw_model(input logic [1:0] ph, input tile_t a, b, t);
      tile_t cur, nx;
      logic [15:0] x, y;
      logic [16:0] s;
      cur = t;
`ifdef FW_DIAG_CLR_EN
      if (ph == 2'b00) for (int i = 0; i < 8; i++) cur[i][i] = 16'h0;
`endif
      for (int kk = 0; kk < 8; kk++) begin
         for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
               case (ph)
                  2'b00: begin x = cur[i][kk]; y = cur[kk][j]; end
                  2'b01: begin x = a[i][kk];   y = cur[kk][j]; end
                  2'b10: begin x = cur[i][kk]; y = a[kk][j];   end
                  default: begin x = a[i][kk]; y = b[kk][j];   end
               endcase
               s = 17'(x) + 17'(y);
               nx[i][j] = (s < 17'(cur[i][j])) ? s[15:0] : cur[i][j];
            end
         cur = nx;
      end
      return cur;
   endfunction

   function automatic tile_t inf_diag();
      tile_t x;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++) x[i][j] = (i == j) ? 16'h0 : 16'hFFFF;
      return x;
   endfunction

   // Output monitor: scoreboard compare, latency and run-length checks.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid) begin
         if (run_len == 0) begin
            if (acc_q.size() == 0) fail("out_valid with no job pending");
            else begin
               ta = acc_q.pop_front();
               chk("latency", 64'(cyc - ta), 64'd9);
            end
         end
         run_len++;
         if (exp_q.size() == 0) fail("outD unexpected word");
         else begin
            ew = exp_q.pop_front();
            chk("outD", bus.outD, ew);
         end
         if (ow < 16) for (int q = 0; q < 4; q++) cap[ow/2][4*(ow%2)+q] = bus.outD[16*q +: 16];
         ow++;
      end else if (run_len != 0) begin
         chk("out_valid run", 64'(run_len), 64'd16);
         run_len = 0;
         ow = 0;
         done_cnt++;
      end
   end

   // Present a job's words, holding each until accepted; nmax truncates it.
   task automatic drive_job(input logic [1:0] ph, input tile_t a, b, t, input int nmax,
                            input int bub2, input int bub15, output int first_acc, output int last_acc);
      int n, nd, idx, guard, seg;
      logic acc;
      tile_t tl, res;
      logic [63:0] w;
      n  = (ph == 2'b00) ? 16 : (ph == 2'b11) ? 48 : 32;
      nd = (nmax < n) ? nmax : n;
      res = fw_model(ph, a, b, t);
      first_acc = -1;
      last_acc  = -1;
      idx = 0;
      while (idx < nd) begin
         seg = idx / 16;
         tl  = (seg == n/16 - 1) ? t : ((seg == 0) ? a : b);
         w   = word_of(tl, idx % 16);
         acc = 1'b0;
         guard = 0;
         while (!acc) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.inD      = w;
            bus.phase    = (idx == 0) ? ph : ~ph;
            acc          = !bus.inhibit;
            if (acc) last_acc = cyc + 1;
            @(posedge clk);
            guard++;
            if (!acc && guard > 100) begin
               fail("accept timeout");
               return;
            end
         end
         if (idx == 0) first_acc = last_acc;
         if (idx == n - 1) begin
            for (int wi = 0; wi < 16; wi++) exp_q.push_back(word_of(res, wi));
            acc_q.push_back(last_acc);
         end
         if (idx == 2 || idx == 15) begin
            for (int b2 = 0; b2 < ((idx == 2) ? bub2 : bub15); b2++) begin
               @(negedge clk);
               bus.in_valid = 1'b0;
               @(posedge clk);
            end
         end
         idx++;
      end
   endtask

   task automatic idle();
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_done(input int target);
      int g = 0;
      while (done_cnt < target && g < 300) begin
         @(posedge clk);
         g++;
      end
      if (done_cnt < target) fail("job completion timeout");
      @(negedge clk);
   endtask

   vec_t  vecs[6];
   tile_t t0, tr, tj;
   int    f1, l1, f2, l2;

   initial begin
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.inD = '0;
      bus.phase = 2'b00;

      // Vector table.
      t0 = inf_diag(); t0[0][1] = 16'd3; t0[1][2] = 16'd4;
      vecs[0] = '{"closure", 2'b00, '0, '0, t0, 0, 2, 16'd7};
      t0 = inf_diag(); t0[0][1] = 16'hFFF0; t0[1][2] = 16'h0020; t0[0][2] = 16'h0100;
      vecs[1] = '{"nowrap", 2'b00, '0, '0, t0, 0, 2, 16'h0100};
      vecs[2] = '{"ph01", 2'b01, inf_diag(), '0, inf_diag(), 0, 5, 16'd3};
      vecs[2].a[0][1] = 16'd2; vecs[2].t[1][5] = 16'd1; vecs[2].t[0][5] = 16'h0050;
      vecs[3] = '{"ph10", 2'b10, inf_diag(), '0, inf_diag(), 0, 2, 16'd7};
      vecs[3].a[1][2] = 16'd5; vecs[3].t[0][1] = 16'd2; vecs[3].t[0][2] = 16'h0050;
      vecs[4] = '{"ph11", 2'b11, '1, '1, '1, 0, 6, 16'd10};
      vecs[4].a[0][3] = 16'd4; vecs[4].b[3][6] = 16'd6;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++) tr[i][j] = (i == j) ? 16'h0 : 16'($urandom_range(1, 200));
      vecs[5] = '{"rand00", 2'b00, '0, '0, tr, -1, -1, 16'd0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset outD", bus.outD, 64'd0);
      chk("reset out_valid", 64'(bus.out_valid), 64'd0);
      chk("reset inhibit", 64'(bus.inhibit), 64'd0);
      rst_n = 1'b1;

      for (int v = 0; v < 6; v++) begin
         drive_job(vecs[v].ph, vecs[v].a, vecs[v].b, vecs[v].t, 99, 0, 0, f1, l1);
         idle();
         wait_done(v + 1);
         if (vecs[v].ci >= 0)
            chk(vecs[v].name, 64'(cap[vecs[v].ci][vecs[v].cj]), 64'(vecs[v].cval));
      end

      // Bubbles inside the job must not change the result.
      drive_job(2'b00, '0, '0, vecs[0].t, 99, 1, 3, f1, l1);
      idle();
      wait_done(7);
      chk("bubble T02", 64'(cap[0][2]), 64'd7);
      chk("bubble T01", 64'(cap[0][1]), 64'd3);

      // Continuous stream: junk presented while busy is dropped, next tile
      // is accepted right after the drain.
      drive_job(2'b00, '0, '0, vecs[0].t, 99, 0, 0, f1, l1);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.inD      = 64'h0001_0001_0001_0001;
         bus.phase    = 2'b11;
         chk("inhibit busy", 64'(bus.inhibit), 64'd1);
         @(posedge clk);
      end
      drive_job(2'b00, '0, '0, vecs[5].t, 99, 0, 0, f2, l2);
      idle();
      chk("back-to-back gap", 64'(f2 - l1), 64'd25);
      wait_done(9);

      // Reset in the middle of a load aborts it cleanly.
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++) tj[i][j] = 16'h0001;
      drive_job(2'b00, '0, '0, tj, 7, 0, 0, f1, l1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      chk("reset out_valid mid", 64'(bus.out_valid), 64'd0);
      chk("reset inhibit mid", 64'(bus.inhibit), 64'd0);
      rst_n = 1'b1;
      drive_job(2'b00, '0, '0, vecs[1].t, 99, 0, 0, f1, l1);
      idle();
      wait_done(10);
      chk("post-reset T02", 64'(cap[0][2]), 64'h0100);
      chk("post-reset T01", 64'(cap[0][1]), 64'hFFF0);

      if (exp_q.size() != 0) fail("scoreboard words left over");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
